mac_seq_ctrl: RTL and testbench
===============================

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter DRAIN_TIMEOUT, default 32, SHALL set the maximum number of DRAIN-state cycles before the block aborts with an error.
REQ-002 CLK  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 RSTN  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 START  in  1  SHALL be a one-cycle job start request.
REQ-005 RELOAD_W  in  1  SHALL request a weight reload; sampled with START.
REQ-006 NVEC  in  8  SHALL give the number of activation vectors in the job; sampled with START.
REQ-007 W_REQ out 1, W_ACK in 1, W_IN in 32 SHALL form the weight-row fetch handshake; one row per accepted beat.
REQ-008 A_VALID in 1, A_READY out 1, A_IN in 32 SHALL form the activation-vector handshake; byte j is the column-j operand.
REQ-009 W_LOAD out 1, WROW out 2, WDATA out 32 SHALL drive the array weight-load port.
REQ-010 IDATA out 32, ICOL_VALID out 4 SHALL drive the array input port.
REQ-011 OVALID in 4 SHALL carry the array row-valid outputs; only bit 3 is used.
REQ-012 BUSY out 1 SHALL be high in every state except IDLE.
REQ-013 DONE out 1 SHALL pulse for one cycle at job end.
REQ-014 TIMEOUT_ERR out 1 SHALL be a sticky drain-timeout flag.

Function
REQ-015 The FSM SHALL have the states IDLE, WLOAD, FEED, DRAIN and FIN.
REQ-016 In IDLE, START with NVEC==0 SHALL be ignored; in all other states, START SHALL be ignored.
REQ-017 IDLE+START SHALL go to WLOAD if RELOAD_W==1 or no weights have been loaded since reset; otherwise it SHALL go to FEED.
REQ-018 START SHALL latch NVEC and clear TIMEOUT_ERR.
REQ-019 WLOAD SHALL hold W_REQ=1 and accept rows 0,1,2,3 in order, one per cycle with W_REQ&W_ACK.
REQ-020 An accepted row in cycle t SHALL produce W_LOAD=1, WROW=row index and WDATA=W_IN in cycle t+1; otherwise W_LOAD=0 and WROW/WDATA hold their values.
REQ-021 The 4th accepted row SHALL move the FSM to FEED and set the internal weights-loaded flag.
REQ-022 FEED SHALL assert A_READY only while the accepted-vector count is below NVEC.
REQ-023 The cycle in which the count reaches NVEC SHALL move the FSM to DRAIN.
REQ-024 Skew: a vector accepted in cycle t SHALL drive IDATA[8j+7:8j]=A_IN[8j+7:8j] and ICOL_VALID[j]=1 in cycle t+1+j, for j=0..3.
REQ-025 Cycles with no handshake SHALL insert a bubble: the skew slot carries valid=0 and data=0.
REQ-026 The skew pipeline SHALL shift every cycle in all states, so the last vector is fully emitted 4 cycles after acceptance even though the FSM has left FEED.
REQ-027 A result counter, cleared on START, SHALL count cycles with OVALID[3]==1 while in FEED or DRAIN.
REQ-028 In DRAIN, when the result count equals the latched NVEC, the FSM SHALL go to FIN.
REQ-029 A DRAIN cycle counter SHALL be cleared on DRAIN entry; if it reaches DRAIN_TIMEOUT first, TIMEOUT_ERR SHALL be set and the FSM SHALL go to FIN.
REQ-030 FIN SHALL assert DONE for exactly one cycle, then go to IDLE.
REQ-031 Counters SHALL be 8 bits wide and SHALL never wrap within a job, since NVEC is at most 255.
REQ-032 If the result count equality and the timeout occur in the same cycle, completion SHALL win and TIMEOUT_ERR SHALL stay 0.
REQ-033 OVALID pulses seen in IDLE, WLOAD or FIN SHALL be ignored.

Reset
REQ-034 While RSTN is low, the FSM SHALL be in IDLE.
REQ-035 While RSTN is low, every output SHALL be 0, the skew pipeline and all counters SHALL be cleared, and the weights-loaded flag SHALL be 0.
REQ-036 Asserting reset mid-job SHALL abandon the job with no DONE pulse; the next START SHALL force WLOAD.

Verification
REQ-037 Post-reset START, NVEC=2, W_ACK always 1, rows 0x01010101..0x04040404 -> W_LOAD high for 4 consecutive cycles with WROW 0,1,2,3; A_READY rises the cycle after the 4th ack.
REQ-038 FEED, A_IN=0x44332211 accepted at t -> IDATA[7:0]=0x11 at t+1, [15:8]=0x22 at t+2, [23:16]=0x33 at t+3, [31:24]=0x44 at t+4, each with only the matching ICOL_VALID bit set.
REQ-039 A_VALID toggling 1,0,1 with NVEC=2 -> ICOL_VALID[0] pattern 1,0,1; A_READY drops after the 2nd accept.
REQ-040 Second START with RELOAD_W=0 -> no W_REQ; FEED entered the next cycle.
REQ-041 NVEC=3 with OVALID[3] never asserted -> DONE exactly DRAIN_TIMEOUT cycles after DRAIN entry plus one, TIMEOUT_ERR=1; the next START clears it.
REQ-042 RSTN pulsed low during FEED -> all outputs 0 immediately, no DONE; the following START performs a full WLOAD.

Source files
------------

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a 4x4 MAC array: loads weight rows, feeds skewed activations, waits for results.
// Latency: weight row and activation column j appear 1 and 1+j cycles after their handshake.
// Backpressure: w_req/a_ready are only held while the FSM can accept; the skew pipeline never stalls.
module mac_seq_ctrl #(
  parameter int DRAIN_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        reload_w,
  input  logic [7:0]  nvec,
  output logic        w_req,
  input  logic        w_ack,
  input  logic [31:0] w_in,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] a_in,
  output logic        w_load,
  output logic [1:0]  wrow,
  output logic [31:0] wdata,
  output logic [31:0] idata,
  output logic [3:0]  icol_valid,
  input  logic [3:0]  ovalid,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WLOAD = 3'd1;
  localparam logic [2:0] S_FEED  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [7:0] TMO = 8'(DRAIN_TIMEOUT);

  logic [2:0]  state;
  logic [7:0]  nvec_q;
  logic [7:0]  acc_cnt;
  logic [7:0]  res_cnt;
  logic [7:0]  drn_cnt;
  logic [1:0]  row_cnt;
  logic        w_loaded;
  logic        w_acc;
  logic        a_acc;
  logic        start_ok;
  logic        res_done;
  logic        unused_ovalid;

  // Skew stages keep only the bytes still waiting to be emitted.
  logic [31:0] s0;
  logic [31:8] s1;
  logic [31:16] s2;
  logic [31:24] s3;
  logic [3:0]  sk_vld;

  assign w_req    = (state == S_WLOAD);
  assign a_ready  = (state == S_FEED) && (acc_cnt < nvec_q);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FIN);
  assign w_acc    = w_req & w_ack;
  assign a_acc    = a_valid & a_ready;
  assign start_ok = (state == S_IDLE) && start && (nvec != 8'd0);
  assign res_done = (res_cnt == nvec_q);

  assign idata      = {s3, s2[23:16], s1[15:8], s0[7:0]};
  assign icol_valid = sk_vld;
  assign unused_ovalid = ^ovalid[2:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      nvec_q      <= 8'd0;
      acc_cnt     <= 8'd0;
      res_cnt     <= 8'd0;
      drn_cnt     <= 8'd0;
      row_cnt     <= 2'd0;
      w_loaded    <= 1'b0;
      w_load      <= 1'b0;
      wrow        <= 2'd0;
      wdata       <= 32'd0;
      timeout_err <= 1'b0;
    end else begin
      w_load <= w_acc;
      if (w_acc) begin
        wrow    <= row_cnt;
        wdata   <= w_in;
        row_cnt <= row_cnt + 2'd1;
      end

      // Results only count while a job can legitimately be producing them.
      if (start_ok)
        res_cnt <= 8'd0;
      else if ((state == S_FEED || state == S_DRAIN) && ovalid[3] && res_cnt != 8'hFF)
        res_cnt <= res_cnt + 8'd1;

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            nvec_q      <= nvec;
            acc_cnt     <= 8'd0;
            row_cnt     <= 2'd0;
            timeout_err <= 1'b0;
            state       <= (reload_w || !w_loaded) ? S_WLOAD : S_FEED;
          end
        end
        S_WLOAD: begin
          if (w_acc && row_cnt == 2'd3) begin
            w_loaded <= 1'b1;
            state    <= S_FEED;
          end
        end
        S_FEED: begin
          if (a_acc) begin
            acc_cnt <= acc_cnt + 8'd1;
            if (acc_cnt + 8'd1 == nvec_q) begin
              drn_cnt <= 8'd0;
              state   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Completion is checked first so a same-cycle timeout never flags an error.
          if (res_done) begin
            state <= S_FIN;
          end else if (drn_cnt == TMO) begin
            timeout_err <= 1'b1;
            state       <= S_FIN;
          end else begin
            drn_cnt <= drn_cnt + 8'd1;
          end
        end
        S_FIN:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0     <= 32'd0;
      s1     <= 24'd0;
      s2     <= 16'd0;
      s3     <= 8'd0;
      sk_vld <= 4'd0;
    end else begin
      s0     <= a_acc ? a_in : 32'd0;
      s1     <= s0[31:8];
      s2     <= s1[31:16];
      s3     <= s2[31:24];
      sk_vld <= {sk_vld[2:0], a_acc};
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: stimulus pushes expected weight rows, column bytes and
// done flags; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mac_seq_ctrl;

  localparam int TMO = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        reload_w = 1'b0;
  logic [7:0]  nvec = 8'd0;
  logic        w_req;
  logic        w_ack = 1'b0;
  logic [31:0] w_in = 32'd0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [31:0] a_in = 32'd0;
  logic        w_load;
  logic [1:0]  wrow;
  logic [31:0] wdata;
  logic [31:0] idata;
  logic [3:0]  icol_valid;
  logic [3:0]  ovalid = 4'd0;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  logic [33:0] wq[$];
  logic [7:0]  cq0[$];
  logic [7:0]  cq1[$];
  logic [7:0]  cq2[$];
  logic [7:0]  cq3[$];
  logic        dq[$];

  logic [31:0] row_a[4] = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
  logic [31:0] row_b[4] = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};
  logic [31:0] vec3[3]  = '{32'h0C0B0A09, 32'h100F0E0D, 32'h14131211};

  mac_seq_ctrl #(.DRAIN_TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .reload_w(reload_w), .nvec(nvec),
    .w_req(w_req), .w_ack(w_ack), .w_in(w_in),
    .a_valid(a_valid), .a_ready(a_ready), .a_in(a_in),
    .w_load(w_load), .wrow(wrow), .wdata(wdata),
    .idata(idata), .icol_valid(icol_valid), .ovalid(ovalid),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [31:0] v);
    cq0.push_back(v[7:0]);
    cq1.push_back(v[15:8]);
    cq2.push_back(v[23:16]);
    cq3.push_back(v[31:24]);
  endtask

  task automatic load_rows(input logic [31:0] r0, input logic [31:0] r1,
                           input logic [31:0] r2, input logic [31:0] r3);
    logic [31:0] rows[4];
    rows = '{r0, r1, r2, r3};
    w_ack = 1'b1;
    for (int r = 0; r < 4; r++) begin
      w_in = rows[r];
      wq.push_back({2'(r), rows[r]});
      tick();
    end
    w_ack = 1'b0;
  endtask

  task automatic pop_col(input int j, input logic [7:0] act);
    logic [7:0] e;
    bit empty;
    empty = 1'b0;
    e = 8'd0;
    case (j)
      0: if (cq0.size() == 0) empty = 1'b1; else e = cq0.pop_front();
      1: if (cq1.size() == 0) empty = 1'b1; else e = cq1.pop_front();
      2: if (cq2.size() == 0) empty = 1'b1; else e = cq2.pop_front();
      default: if (cq3.size() == 0) empty = 1'b1; else e = cq3.pop_front();
    endcase
    checks++;
    if (empty) begin
      errors++;
      $display("FAIL col%0d_unexpected got=%0h want=none", j, act);
    end else if (act !== e) begin
      errors++;
      $display("FAIL col%0d_data got=%0h want=%0h", j, act, e);
    end
  endtask

  // Monitor: consumes whatever the DUT presents.
  always @(negedge clk) begin
    if (rstn) begin
      if (w_load) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wload_unexpected got=%0h want=none", {wrow, wdata});
        end else begin
          logic [33:0] e;
          e = wq.pop_front();
          if ({wrow, wdata} !== e) begin
            errors++;
            $display("FAIL wload_row got=%0h want=%0h", {wrow, wdata}, e);
          end
        end
      end
      for (int j = 0; j < 4; j++) begin
        if (icol_valid[j]) pop_col(j, idata[8*j +: 8]);
        else chk("bubble_zero", 64'(idata[8*j +: 8]), 64'd0);
      end
      if (done) begin
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got=1 want=0");
        end else begin
          logic e;
          e = dq.pop_front();
          if (timeout_err !== e) begin
            errors++;
            $display("FAIL done_err got=%0b want=%0b", timeout_err, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 64'({busy, w_req, a_ready, done, w_load, timeout_err, wrow, icol_valid}), 64'd0);
    chk("rst_data", 64'({wdata, idata}), 64'd0);
    tick();
    rstn = 1'b1;
    tick();

    // NVEC==0 start is ignored
    start = 1'b1; nvec = 8'd0;
    tick();
    start = 1'b0;
    chk("nvec0_ignored", 64'(busy), 64'd0);

    // Job 1: forced weight load, skew/bubble, normal completion
    start = 1'b1; nvec = 8'd2; reload_w = 1'b0;
    dq.push_back(1'b0);
    tick();
    start = 1'b0;
    chk("j1_wreq", 64'({w_req, a_ready, busy}), 64'b101);
    ovalid = 4'b1111;
    w_ack = 1'b1; w_in = row_a[0]; wq.push_back({2'd0, row_a[0]});
    tick();
    ovalid = 4'd0;
    for (int r = 1; r < 4; r++) begin
      w_in = row_a[r];
      wq.push_back({2'(r), row_a[r]});
      tick();
    end
    w_ack = 1'b0;
    chk("j1_aready_rise", 64'({a_ready, w_req}), 64'b10);
    a_valid = 1'b1; a_in = 32'h44332211; push_vec(a_in);
    tick();
    a_valid = 1'b0;
    chk("j1_skew_t1", 64'({icol_valid, idata}), {28'd0, 4'b0001, 32'h00000011});
    chk("j1_wdata_hold", 64'({w_load, wrow, wdata}), {29'd0, 1'b0, 2'd3, 32'h04040404});
    tick();
    chk("j1_skew_t2", 64'({icol_valid, idata}), {28'd0, 4'b0010, 32'h00002200});
    chk("j1_aready_mid", 64'(a_ready), 64'd1);
    a_valid = 1'b1; a_in = 32'h88776655; push_vec(a_in);
    tick();
    a_valid = 1'b0;
    chk("j1_skew_t3", 64'({icol_valid, idata}), {28'd0, 4'b0101, 32'h00330055});
    chk("j1_aready_drop", 64'(a_ready), 64'd0);
    ovalid = 4'b1000;
    tick();
    tick();
    ovalid = 4'd0;
    chk("j1_no_done_yet", 64'(done), 64'd0);
    tick();
    chk("j1_done", 64'({done, busy, timeout_err}), 64'b110);
    tick();
    chk("j1_idle", 64'({done, busy}), 64'b00);

    // Job 2: no reload, drain timeout, START ignored while busy
    start = 1'b1; nvec = 8'd3; reload_w = 1'b0;
    dq.push_back(1'b1);
    tick();
    start = 1'b0;
    chk("j2_feed_direct", 64'({w_req, a_ready, busy}), 64'b011);
    a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_in = vec3[k];
      push_vec(a_in);
      tick();
    end
    a_valid = 1'b0;
    chk("j2_drain_entry", 64'({a_ready, busy}), 64'b01);
    start = 1'b1; nvec = 8'd5; reload_w = 1'b1;
    tick();
    start = 1'b0; reload_w = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("j2_timeout_latency", 64'(n), 64'(TMO + 1));
    chk("j2_timeout_err", 64'(timeout_err), 64'd1);
    tick();
    chk("j2_err_sticky", 64'({timeout_err, busy}), 64'b10);

    // Job 3: reload requested, START clears error, reset mid-FEED
    start = 1'b1; nvec = 8'd2; reload_w = 1'b1;
    tick();
    start = 1'b0; reload_w = 1'b0;
    chk("j3_err_cleared", 64'({timeout_err, w_req}), 64'b01);
    load_rows(row_b[0], row_b[1], row_b[2], row_b[3]);
    a_valid = 1'b1; a_in = 32'hDEADBEEF; push_vec(a_in);
    tick();
    a_valid = 1'b0;
    chk("j3_pre_reset", 64'({icol_valid, a_ready}), 64'b00011);
    rstn = 1'b0;
    wq.delete(); cq0.delete(); cq1.delete(); cq2.delete(); cq3.delete(); dq.delete();
    #1;
    chk("j3_rst_ctrl", 64'({busy, w_req, a_ready, done, w_load, timeout_err, wrow, icol_valid}), 64'd0);
    chk("j3_rst_data", 64'({wdata, idata}), 64'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Job 4: reset forces WLOAD; result count and timeout coincide, completion wins
    start = 1'b1; nvec = 8'd1; reload_w = 1'b0;
    dq.push_back(1'b0);
    tick();
    start = 1'b0;
    chk("j4_forced_wload", 64'(w_req), 64'd1);
    load_rows(row_a[0], row_a[1], row_a[2], row_a[3]);
    a_valid = 1'b1; a_in = 32'h0BADF00D; push_vec(a_in);
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < TMO - 1; i++) tick();
    ovalid = 4'b1000;
    tick();
    ovalid = 4'd0;
    chk("j4_pre_done", 64'(done), 64'd0);
    tick();
    chk("j4_done_no_err", 64'({done, timeout_err}), 64'b10);
    repeat (6) tick();

    chk("drain_wq", 64'(wq.size()), 64'd0);
    chk("drain_cq", 64'(cq0.size() + cq1.size() + cq2.size() + cq3.size()), 64'd0);
    chk("drain_dq", 64'(dq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
